// File: rtl/cgra_cfg_sequencer.sv
// cgra_cfg_sequencer: buffers (addr, data, last) config commands in a small
// FIFO and, on start, replays them as single-cycle config writes to the CGRA
// while holding it stalled, releasing the stall after the entry marked last.
// Optional readback verification is enabled by defining CGRA_CFG_VERIFY_EN.
module cgra_cfg_sequencer #(
  parameter int         FIFO_DEPTH = 4,
  parameter int         SETTLE_CYC = 2,
  parameter int         READ_WAIT  = 2,
  parameter logic [3:0] RUN_STALL  = 4'b0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  input  logic        cmd_last_i,
  input  logic [31:0] CGRA_read_config_data,
  output logic [31:0] CGRA_config_config_addr,
  output logic [31:0] CGRA_config_config_data,
  output logic        CGRA_config_write,
  output logic        CGRA_config_read,
  output logic [3:0]  CGRA_stall,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [15:0] word_count_o
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int SCW = $clog2(SETTLE_CYC + 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_FETCH, S_WRITE, S_CHECK_LAST, S_RELEASE, S_RDWAIT, S_COMPARE
  } state_t;

  state_t          state_q, state_d;
  logic [64:0]     fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_full, fifo_empty;
  logic            push, pop, flush;
  logic [SCW-1:0]  settle_cnt;
  logic [31:0]     cfg_addr, cfg_data;
  logic            cfg_last;
  logic [3:0]      stall_q;
  logic [15:0]     word_cnt;

  assign fifo_full   = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty  = (fifo_cnt == '0);
  assign cmd_ready_o = ~fifo_full;
  assign push        = cmd_valid_i & ~fifo_full;

`ifdef CGRA_CFG_VERIFY_EN
  localparam int RCW = $clog2(READ_WAIT + 1);
  localparam logic [RCW-1:0] READ_LAST = RCW'(READ_WAIT - 1);
  logic [RCW-1:0] rd_cnt;
  logic           err_q;
  logic           mismatch;
  assign mismatch = (CGRA_read_config_data != cfg_data);
`endif

  // State register for the sequencing FSM.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic plus the FIFO pop and flush requests it produces.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE:       if (start_i) state_d = S_SETTLE;
      S_SETTLE:     if (settle_cnt == SETTLE_LAST) state_d = S_FETCH;
      S_FETCH: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_WRITE;
        end
      end
`ifdef CGRA_CFG_VERIFY_EN
      S_WRITE:      state_d = S_RDWAIT;
      S_RDWAIT:     if (rd_cnt == READ_LAST) state_d = S_COMPARE;
      S_COMPARE: begin
        if (mismatch) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CHECK_LAST;
        end
      end
`else
      S_WRITE:      state_d = S_CHECK_LAST;
`endif
      S_CHECK_LAST: state_d = cfg_last ? S_RELEASE : S_FETCH;
      S_RELEASE:    state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Command storage; entries discarded by a flush are simply overwritten later.
  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= {cmd_last_i, cmd_data_i, cmd_addr_i};
  end

  // FIFO pointers and occupancy; a flush empties the queue and wins over a push.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Pass datapath: stall level, settle timer, current command, write counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      stall_q    <= 4'b1111;
      settle_cnt <= '0;
      cfg_addr   <= '0;
      cfg_data   <= '0;
      cfg_last   <= 1'b0;
      word_cnt   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            stall_q    <= 4'b1111;
            settle_cnt <= '0;
            word_cnt   <= '0;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt + SCW'(1);
        S_FETCH: begin
          if (pop) {cfg_last, cfg_data, cfg_addr} <= fifo_mem[rd_ptr];
        end
        S_WRITE:   if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
        S_RELEASE: stall_q <= RUN_STALL;
        default: ;
      endcase
    end
  end

`ifdef CGRA_CFG_VERIFY_EN
  // Readback wait timer and the sticky mismatch flag, cleared by the next start.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE:    if (start_i) err_q <= 1'b0;
        S_WRITE:   rd_cnt <= '0;
        S_RDWAIT:  rd_cnt <= rd_cnt + RCW'(1);
        S_COMPARE: if (mismatch) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign CGRA_config_read = (state_q == S_RDWAIT);
  assign err_o            = err_q;
`else
  logic unused_readback;
  assign unused_readback  = ^{CGRA_read_config_data, 32'(READ_WAIT)};
  assign CGRA_config_read = 1'b0;
  assign err_o            = 1'b0;
`endif

  assign CGRA_config_config_addr = cfg_addr;
  assign CGRA_config_config_data = cfg_data;
  assign CGRA_config_write       = (state_q == S_WRITE);
  assign CGRA_stall              = stall_q;
  assign busy_o                  = (state_q != S_IDLE);
  assign done_o                  = (state_q == S_RELEASE);
  assign word_count_o            = word_cnt;

endmodule

// File: doc/cgra_cfg_sequencer.md
Name: cgra_cfg_sequencer

Overview:
- Autonomous configuration sequencer for the CGRA config port.
- Buffers a stream of (address, data, last) config commands in an internal FIFO.
- On start: holds the CGRA stalled, issues one single-cycle config write per entry, then releases stall after the last entry.
- Sits between the wishbone control/CSR logic (command producer) and the CGRA config/stall inputs; replaces software-driven write-by-write sequencing.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- SETTLE_CYC, 2, cycles stall is held before the first write; ≥1.
- READ_WAIT, 2, cycles config_read is held before readback is sampled (verify only); ≥1.
- RUN_STALL, 4'b0000, stall value driven after successful completion.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  single-cycle pulse; begins a configuration pass.
- cmd_valid_i  in  1  command push request.
- cmd_ready_o  out  1  FIFO not full.
- cmd_addr_i  in  32  config address.
- cmd_data_i  in  32  config data.
- cmd_last_i  in  1  marks final command of the pass.
- CGRA_read_config_data  in  32  readback data from CGRA.
- CGRA_config_config_addr  out  32  config address to CGRA.
- CGRA_config_config_data  out  32  config data to CGRA.
- CGRA_config_write  out  1  single-cycle write strobe.
- CGRA_config_read  out  1  read enable, level (multicycle).
- CGRA_stall  out  4  per-quadrant stall.
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  sticky readback mismatch (verify only).
- word_count_o  out  16  writes issued this pass; saturates at 16'hFFFF.

Behaviour:
- Reset values (async, wb_rst_ni=0): FSM=IDLE, FIFO empty, addr/data=0, write=0, read=0, CGRA_stall=4'b1111, busy=0, done=0, err=0, word_count=0.
- FIFO:
  - Push when cmd_valid_i & cmd_ready_o; cmd_ready_o = !full (registered count).
  - Pop only in FETCH when non-empty; no same-cycle bypass (a push into an empty FIFO is poppable next cycle).
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pushes are accepted in any state, including IDLE.
- FSM:
  - IDLE: start_i → SETTLE; CGRA_stall←4'b1111, word_count←0, err←0, settle counter←0. Otherwise outputs hold.
  - SETTLE: count SETTLE_CYC cycles → FETCH.
  - FETCH: if FIFO empty, wait (stall held, no timeout). Else pop; register addr/data/last → WRITE.
  - WRITE: CGRA_config_write=1 for exactly this cycle; word_count+1 (saturating). Then → VERIFY (macro on) or → CHECK_LAST.
  - CHECK_LAST: last → RELEASE, else → FETCH. Write-to-write spacing is therefore ≥3 cycles.
  - RELEASE: CGRA_stall←RUN_STALL; done_o=1 for one cycle → IDLE.
- Config addr/data stay stable from FETCH until the next pop.
- start_i is ignored when not in IDLE.
- cmd_last_i on an entry ends the pass even if more entries remain queued; remaining entries stay for the next pass.
- busy_o = (state != IDLE).

Optional Feature:
- Macro CGRA_CFG_VERIFY_EN.
- Defined:
  - After WRITE → RDWAIT: CGRA_config_read=1 for READ_WAIT cycles, same addr.
  - Then COMPARE: read deasserts; sample CGRA_read_config_data against data.
  - Equal → CHECK_LAST.
  - Mismatch → err_o←1 (sticky until next start), FIFO flushed (pointers reset), → IDLE with CGRA_stall held 4'b1111 and no done pulse.
- Undefined: no RDWAIT/COMPARE states; CGRA_config_read tied 0; err_o tied 0.

Test Plan:
- Push 3 cmds (0x10/0xA, 0x14/0xB, 0x18/0xC, last on 3rd), then start → stall 1111 for SETTLE_CYC=2 cycles; exactly 3 write pulses with matching addr/data; stall→0000; done pulse; word_count=3.
- Push 4 cmds with FIFO_DEPTH=4 → cmd_ready_o=0; a 5th push is held off; after start pops, ready returns 1 and the 5th is accepted.
- Start with empty FIFO → stall 1111, busy=1, no writes; push 1 cmd with last → write occurs 2 cycles later (pop, then write); completes.
- Assert wb_rst_ni=0 mid-pass after 1 write → all outputs return to reset values immediately; FIFO empty; stall=1111.
- Start pulse while busy → ignored; word_count is not cleared.
- CGRA_CFG_VERIFY_EN with a model returning data^1 on the 2nd cmd → read held 2 cycles per entry; err_o=1; no done; stall stays 1111; FIFO empty; word_count=2.
